keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Drives a 4x4 membrane keypad matrix and produces the debounced 15-bit key vector that the synth core consumes on keypad_i.
- Sits in the synth top level between the breakout GPIO pins and the synth core.
- Row pins are outputs, column pins are inputs with external pull-ups; the 16th matrix position is unused.

Parameters:
- SETTLE_CYCLES, 1000: clock cycles each row is driven before its columns are sampled (>=3).
- DEBOUNCE_FRAMES, 4: consecutive identical full-matrix frames required before keys_o updates (>=2).

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- en  input  1  scan enable (synth chip-select, active high)
- col_i  input  4  matrix columns, active-low (low = key closed in driven row)
- row_o  output  4  matrix rows, active-low one-cold drive
- keys_o  output  15  debounced key vector, bit k = key k pressed; to synth keypad_i
- keys_changed_o  output  1  one-cycle pulse when keys_o changes value
- frame_done_o  output  1  one-cycle pulse at the end of every complete 4-row scan

Behaviour:
- Reset values: row_o=4'hF, keys_o=0, keys_changed_o=0, frame_done_o=0, FSM=IDLE, all counters/raw/prev frame registers=0, synchronizer flops=4'hF.
- col_i passes through a 2-flop synchronizer, reset to 4'hF. The sampled value is col_s = ~sync_out.
- Key index k = row*4 + col. Index 15 (row 3, col 3) is discarded.
- FSM states:
  - IDLE: row_o=F. If en=1, go to DRIVE with row=0 and settle_cnt=0.
  - DRIVE: row_o = ~(1<<row). settle_cnt increments each cycle. In the cycle settle_cnt==SETTLE_CYCLES-1, capture col_s into raw[row*4 +: 4] and reset settle_cnt. If row<3, row++ and stay in DRIVE; if row==3, go to EVAL.
  - EVAL (one cycle): row_o=F and frame_done_o=1. Compare raw[14:0] with prev. If equal, stable_cnt = sat(stable_cnt+1); otherwise stable_cnt=1. Then prev<=raw[14:0].
    - If the new stable_cnt==DEBOUNCE_FRAMES and raw[14:0]!=keys_o: keys_o<=raw[14:0] and keys_changed_o pulses in the following cycle, aligned with the keys_o update.
    - Return to DRIVE with row=0.
- Frame length = 4*SETTLE_CYCLES + 1 cycles.
- Debounce latency: a stable press appears on keys_o at most (DEBOUNCE_FRAMES+1) frames plus 2 sync cycles after the edge.
- stable_cnt saturates at DEBOUNCE_FRAMES; no wrap-around.
- en deasserted in any state: on the next edge, go to IDLE with row_o=F, counters and raw cleared, stable_cnt=0, prev=0. If keys_o!=0, keys_o<=0 with a keys_changed_o pulse.
- en reasserted: the scan restarts from row 0 with a full debounce requirement.
- Multiple simultaneous keys are reported as-is; ghosting is not masked.
- Asynchronous reset mid-scan: all outputs return to reset values immediately; no pulse is generated.
- keys_changed_o and frame_done_o are registered single-cycle pulses and are never held.

Decomposition:
- Shared package synth_pkg:
  - constants NUM_ROWS=4, NUM_COLS=4, NUM_KEYS=15;
  - scan_state_t enum {IDLE, DRIVE, EVAL};
  - key-index helper function.
- One sub-module: keypad_col_sync, a 4-bit 2-flop synchronizer with async active-low reset to all-ones.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_FRAMES=3, so a frame is 17 cycles.
1. Reset, en=1, no keys -> row_o cycles E,D,B,7 for 4 cycles each, then F for 1 cycle. frame_done_o pulses every 17 cycles. keys_o stays 0 and keys_changed_o never pulses.
2. Hold col_i[2] low whenever row_o==4'hD (key 6) -> keys_o becomes 15'h0040 with one keys_changed_o pulse, no later than 4 frames after press. Release -> keys_o returns to 0 after the same debounce delay.
3. Key 6 bouncing, toggled every alternate frame for 10 frames -> keys_o stays 0 and no keys_changed_o pulse. Then hold steady -> update after 3 equal frames.
4. Hold col_i[3] low during row 3 (index 15) plus col_i[0] low during row 0 -> keys_o=15'h0001; bit 15 never appears.
5. Key 6 debounced (keys_o=0x0040), then en=0 mid-row-2 -> next cycle row_o=F, keys_o=0, keys_changed_o pulses once. en=1 -> scan resumes at row 0 and 0x0040 reappears after 3 frames.
6. Async n_rst low mid-DRIVE with keys_o=0x0040 -> outputs immediately return to reset values. After release with en=1, the first frame starts at row 0.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared keypad matrix constants, scan state type and key index helper
package synth_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 15;

    // Matrix position 15 (row 3, col 3) has no key behind it.
    localparam logic [3:0] UNUSED_KEY = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EVAL  = 2'd2
    } scan_state_t;

    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// rtl/keypad_col_sync.sv - two-flop synchronizer for the active-low column inputs
module keypad_col_sync
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_COLS-1:0] d,
    output logic [NUM_COLS-1:0] q
);

    logic [NUM_COLS-1:0] meta;

    // Resets to all-ones so an idle (pulled-up) column reads as open.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with full-frame debounce
module keypad_scanner
    import synth_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic [NUM_COLS-1:0] col_i,
    output logic [NUM_ROWS-1:0] row_o,
    output logic [NUM_KEYS-1:0] keys_o,
    output logic                keys_changed_o,
    output logic                frame_done_o
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] STABLE_MAX  = DW'(DEBOUNCE_FRAMES);

    logic [NUM_COLS-1:0] col_sync;
    logic [NUM_COLS-1:0] col_s;

    scan_state_t         state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [NUM_KEYS-1:0] raw_q, raw_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [DW-1:0]       stable_q, stable_d;
    logic [DW-1:0]       stable_new;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic                changed_q, changed_d;
    logic                done_q, done_d;
    logic [3:0]          idx;

    keypad_col_sync u_col_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (col_i),
        .q     (col_sync)
    );

    assign col_s = ~col_sync;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_q     <= '0;
            settle_q  <= '0;
            raw_q     <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            keys_q    <= '0;
            changed_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            row_q     <= row_d;
            settle_q  <= settle_d;
            raw_q     <= raw_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            keys_q    <= keys_d;
            changed_q <= changed_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        settle_d   = settle_q;
        raw_d      = raw_q;
        prev_d     = prev_q;
        stable_d   = stable_q;
        keys_d     = keys_q;
        changed_d  = 1'b0;
        done_d     = 1'b0;
        stable_new = '0;
        idx        = '0;

        if (!en) begin
            // Disabling abandons the scan; a fresh enable needs a full debounce.
            state_d  = IDLE;
            row_d    = '0;
            settle_d = '0;
            raw_d    = '0;
            prev_d   = '0;
            stable_d = '0;
            if (keys_q != '0) begin
                keys_d    = '0;
                changed_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end

                DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        for (int c = 0; c < NUM_COLS; c++) begin
                            idx = key_index(row_q, 2'(c));
                            if (idx != UNUSED_KEY) begin
                                raw_d[idx] = col_s[c];
                            end
                        end
                        if (row_q == 2'd3) begin
                            state_d = EVAL;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end

                EVAL: begin
                    if (raw_q == prev_q) begin
                        stable_new = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + DW'(1);
                    end else begin
                        stable_new = DW'(1);
                    end
                    stable_d = stable_new;
                    prev_d   = raw_q;
                    if ((stable_new == STABLE_MAX) && (raw_q != keys_q)) begin
                        keys_d    = raw_q;
                        changed_d = 1'b1;
                    end
                    state_d  = DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        row_o = '1;
        if (state_q == DRIVE) begin
            row_o = ~(4'b0001 << row_q);
        end
    end

    assign keys_o         = keys_q;
    assign keys_changed_o = changed_q;
    assign frame_done_o   = done_q;

endmodule
